// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
//
// Splits one single-byte RTC register access into an address phase and a
// data phase on the multiplexed AD bus. Each phase enables the downstream
// strobe timing generator for one full generator cycle (PHASE_LEN clocks).
// GAP_LEN idle clocks between the phases let the generator counters return
// to zero. The block also owns the 8-bit pad driver and captures read data.
//
// Ports
//   clkW       in   1  system clock, rising edge
//   resetAD_n  in   1  asynchronous active-low reset
//   start      in   1  request strobe, only sampled while idle
//   rw         in   1  1 = read, 0 = write (sampled with start)
//   addr       in   8  RTC register address (sampled with start)
//   wdata      in   8  write data (sampled with start)
//   busy       out  1  transaction in progress
//   done       out  1  one-cycle completion pulse
//   rdata      out  8  last captured read data
//   en_tim     out  1  strobe generator enable
//   c_ad_tim   out  1  generator phase select: 1 = WR strobing, 0 = RD strobing
//   bus_out    out  8  data driven onto the AD bus
//   bus_oe     out  1  pad output enable
//   bus_in     in   8  AD bus pad input
//
// All outputs are registered. With start sampled at edge E0, done is high for
// the cycle following edge E0 + 2*PHASE_LEN + GAP_LEN + 1 - 1.

module rtc_bus_sequencer #(
  parameter int PHASE_LEN = 23,
  parameter int GAP_LEN   = 2,
  parameter int SAMPLE_AT = 15
) (
  input  logic       clkW,
  input  logic       resetAD_n,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       en_tim,
  output logic       c_ad_tim,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in
);

  localparam int CNT_W = $clog2(PHASE_LEN);
  // +1 keeps the gap counter at least one bit wide when GAP_LEN is 1
  localparam int GAP_W = $clog2(GAP_LEN + 1);

  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_LEN - 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_AT);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    GAP  = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] phase_cnt;
  logic [GAP_W-1:0] gap_cnt;

  // Latched copies of the request; the request inputs may change freely
  // once the transaction has been accepted.
  logic             rw_q;
  logic [7:0]       addr_q;
  logic [7:0]       wdata_q;

  always_ff @(posedge clkW or negedge resetAD_n) begin
    if (!resetAD_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      gap_cnt   <= '0;
      rw_q      <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= 8'h00;
      en_tim    <= 1'b0;
      c_ad_tim  <= 1'b0;
      bus_out   <= 8'h00;
      bus_oe    <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the DATA->DONE transition raises it
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            rw_q      <= rw;
            addr_q    <= addr;
            wdata_q   <= wdata;
            phase_cnt <= '0;
            gap_cnt   <= '0;
            state     <= ADDR;
            // Address phase outputs go live on the accepting edge so the
            // bus is valid for the generator's entire first cycle.
            busy      <= 1'b1;
            en_tim    <= 1'b1;
            c_ad_tim  <= 1'b1;
            bus_oe    <= 1'b1;
            bus_out   <= addr;
          end
        end

        ADDR: begin
          if (phase_cnt == PHASE_LAST) begin
            phase_cnt <= '0;
            gap_cnt   <= '0;
            state     <= GAP;
            en_tim    <= 1'b0;
            bus_oe    <= 1'b0;
            bus_out   <= 8'h00;
            // c_ad_tim deliberately held through the gap
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt   <= '0;
            phase_cnt <= '0;
            state     <= DATA;
            en_tim    <= 1'b1;
            if (rw_q) begin
              // Read: release the bus so the RTC can drive it
              c_ad_tim <= 1'b0;
              bus_oe   <= 1'b0;
              bus_out  <= 8'h00;
            end else begin
              c_ad_tim <= 1'b1;
              bus_oe   <= 1'b1;
              bus_out  <= wdata_q;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        DATA: begin
          // Capture late in the RD-low window, after the RTC output settles
          if (rw_q && (phase_cnt == SAMPLE_CNT)) begin
            rdata <= bus_in;
          end
          if (phase_cnt == PHASE_LAST) begin
            phase_cnt <= '0;
            state     <= DONE;
            done      <= 1'b1;
            en_tim    <= 1'b0;
            c_ad_tim  <= 1'b0;
            bus_oe    <= 1'b0;
            bus_out   <= 8'h00;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          en_tim   <= 1'b0;
          c_ad_tim <= 1'b0;
          bus_oe   <= 1'b0;
          bus_out  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
module tb_rtc_bus_sequencer;

  logic       clkW = 1'b0;
  logic       resetAD_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] bus_in = 8'hFF;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       en_tim;
  logic       c_ad_tim;
  logic [7:0] bus_out;
  logic       bus_oe;

  int checks = 0;
  int errors = 0;

  rtc_bus_sequencer #(
    .PHASE_LEN(23),
    .GAP_LEN  (2),
    .SAMPLE_AT(15)
  ) dut (
    .clkW     (clkW),
    .resetAD_n(resetAD_n),
    .start    (start),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .en_tim   (en_tim),
    .c_ad_tim (c_ad_tim),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .bus_in   (bus_in)
  );

  always #5 clkW = ~clkW;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clkW);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk8({tag, "_rdata"}, rdata, 8'h00);
    chk1({tag, "_en_tim"}, en_tim, 1'b0);
    chk1({tag, "_c_ad_tim"}, c_ad_tim, 1'b0);
    chk8({tag, "_bus_out"}, bus_out, 8'h00);
    chk1({tag, "_bus_oe"}, bus_oe, 1'b0);
  endtask

  // One transaction started from IDLE. After the accepting edge E0 the bench
  // sits 1 time unit after edge E(k) for k = 0..49 and checks the
  // hand-derived cycle table: ADDR k=0..22, GAP k=23..24, DATA k=25..47,
  // DONE k=48, IDLE again from k=49.
  task automatic run_txn(input string tag, input logic rd, input logic [7:0] a,
                         input logic [7:0] w, input logic [7:0] exp_rdata,
                         input bit poke);
    int  dcnt;
    int  dk;
    logic exp_en;
    logic exp_oe;
    start = 1'b1; rw = rd; addr = a; wdata = w;
    cyc();
    start = 1'b0; rw = ~rd; addr = ~a; wdata = ~w;
    dcnt = 0;
    for (int k = 0; k <= 49; k++) begin
      dk = k - 25;
      bus_in = (rd && dk >= 14 && dk <= 16) ? 8'h59 : 8'hFF;
      start  = (poke && (k == 10 || k == 30)) ? 1'b1 : 1'b0;
      exp_en = (k <= 22) || (k >= 25 && k <= 47);
      exp_oe = (k <= 22) || (!rd && k >= 25 && k <= 47);
      chk1($sformatf("%s_busy_k%0d", tag, k), busy, (k <= 48));
      chk1($sformatf("%s_done_k%0d", tag, k), done, (k == 48));
      chk1($sformatf("%s_en_k%0d", tag, k), en_tim, exp_en);
      chk1($sformatf("%s_oe_k%0d", tag, k), bus_oe, exp_oe);
      if (k <= 24)
        chk1($sformatf("%s_cad_k%0d", tag, k), c_ad_tim, 1'b1);
      else if (k <= 47)
        chk1($sformatf("%s_cad_k%0d", tag, k), c_ad_tim, !rd);
      if (k <= 22)
        chk8($sformatf("%s_out_k%0d", tag, k), bus_out, a);
      else if (k >= 25 && k <= 47)
        chk8($sformatf("%s_out_k%0d", tag, k), bus_out, rd ? 8'h00 : w);
      if (k == 48 || k == 49)
        chk8($sformatf("%s_rdata_k%0d", tag, k), rdata, exp_rdata);
      if (done) dcnt++;
      if (k < 49) cyc();
    end
    start = 1'b0;
    bus_in = 8'hFF;
    chk_int({tag, "_done_count"}, dcnt, 1);
  endtask

  initial begin
    // Reset held with a start request pending
    resetAD_n = 1'b0;
    start = 1'b1; rw = 1'b0; addr = 8'h33; wdata = 8'h44;
    repeat (3) cyc();
    chk_reset_outputs("rst");
    start = 1'b0;
    resetAD_n = 1'b1;
    repeat (5) cyc();
    chk1("rst_idle_busy", busy, 1'b0);
    chk1("rst_idle_en", en_tim, 1'b0);

    // Write: rdata must stay at its reset value
    run_txn("wr", 1'b0, 8'h0A, 8'h26, 8'h00, 1'b0);
    cyc();

    // Read: bus_in carries 8'h59 only in DATA counts 14..16
    run_txn("rd", 1'b1, 8'h04, 8'h00, 8'h59, 1'b0);
    cyc();

    // Busy rejection: start pulses at k=10 and k=30 must be ignored
    run_txn("rej", 1'b0, 8'h11, 8'hC3, 8'h59, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk1($sformatf("rej_after_busy_%0d", i), busy, 1'b0);
      chk1($sformatf("rej_after_done_%0d", i), done, 1'b0);
    end

    // Back-to-back: start held high, transactions every 50 cycles
    start = 1'b1; rw = 1'b0; addr = 8'h5A; wdata = 8'hA5;
    cyc();
    for (int k = 0; k <= 150; k++) begin
      chk1($sformatf("b2b_done_k%0d", k), done, ((k % 50) == 48));
      chk1($sformatf("b2b_busy_k%0d", k), busy, ((k % 50) != 49));
      if (k < 150) cyc();
    end
    start = 1'b0;
    for (int i = 0; i < 60 && busy; i++) cyc();
    chk1("b2b_drain_busy", busy, 1'b0);
    cyc();

    // Mid-op reset during the DATA phase of a read, after rdata was captured
    bus_in = 8'h5B;
    start = 1'b1; rw = 1'b1; addr = 8'h04;
    cyc();
    start = 1'b0;
    repeat (45) cyc();
    chk1("mid_pre_en", en_tim, 1'b1);
    chk1("mid_pre_cad", c_ad_tim, 1'b0);
    chk8("mid_pre_rdata", rdata, 8'h5B);
    #2;
    resetAD_n = 1'b0;
    #1;
    chk_reset_outputs("mid_async");
    repeat (4) cyc();
    chk1("mid_hold_done", done, 1'b0);
    resetAD_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk1($sformatf("mid_post_busy_%0d", i), busy, 1'b0);
      chk1($sformatf("mid_post_done_%0d", i), done, 1'b0);
      chk1($sformatf("mid_post_en_%0d", i), en_tim, 1'b0);
    end
    chk8("mid_post_rdata", rdata, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Transaction sequencer for the RTC multiplexed address/data bus. It accepts single-byte read or write requests from the register controller and splits each one into an address phase and a data phase. For each phase it drives the enable and address/data-select inputs of the strobe timing generator, which sits directly downstream. It also owns the 8-bit bus driver: output data and output enable go to the pad tri-state, and it captures read data from the pad input.

## Interface
- PHASE_LEN, 23: cycles per bus phase; matches one full strobe-generator cycle.
- GAP_LEN, 2: idle cycles with enable low between phases, so the generator's counters return to 0.
- SAMPLE_AT, 15: phase-counter value in the read data phase at which bus_in is captured (RD is low on counts 3..16).
- clkW  in  1  system clock, rising edge.
- resetAD_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- rw  in  1  1 = read, 0 = write; sampled with start.
- addr  in  8  RTC register address; sampled with start.
- wdata  in  8  write data; sampled with start.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- rdata  out  8  captured read data; holds until the next read completes.
- en_tim  out  1  enable to the strobe timing generator.
- c_ad_tim  out  1  phase select to the generator; 1 = address/write strobing (WR), 0 = read strobing (RD).
- bus_out  out  8  data driven onto the AD bus.
- bus_oe  out  1  pad output enable; 1 = drive bus_out.
- bus_in  in  8  AD bus pad input.

## Operation
- FSM states: IDLE, ADDR, GAP, DATA, DONE. Phase counter width is ceil(log2(PHASE_LEN)) bits. A separate gap counter is used.
- IDLE: all outputs inactive.
  - On start=1, latch rw, addr and wdata into internal registers.
  - Clear the counters and go to ADDR.
- ADDR: en_tim=1, c_ad_tim=1, bus_oe=1, bus_out=latched addr.
  - Counter runs 0..PHASE_LEN-1.
  - At PHASE_LEN-1, go to GAP.
- GAP: en_tim=0, c_ad_tim keeps its previous value, bus_oe=0.
  - Lasts GAP_LEN cycles, then go to DATA.
- DATA, write: en_tim=1, c_ad_tim=1, bus_oe=1, bus_out=latched wdata.
- DATA, read: en_tim=1, c_ad_tim=0, bus_oe=0, bus_out=0.
  - When counter==SAMPLE_AT, rdata<=bus_in.
- DATA, both: at PHASE_LEN-1, go to DONE.
- DONE: done=1, busy=1, en_tim=0, bus_oe=0. Next state is IDLE unconditionally.
- busy=1 in every state except IDLE.
- start asserted outside IDLE is ignored and not queued.
- A start in the IDLE cycle right after DONE is accepted normally.
- Request inputs may change freely after acceptance; only the latched copies are used.

## Timing
- Reset values: busy=0, done=0, rdata=8'h00, en_tim=0, c_ad_tim=0, bus_out=8'h00, bus_oe=0, state=IDLE, counters=0.
- All outputs are registered. Let start be sampled high at edge E0.
  - ADDR occupies the cycles after E0..E23.
  - GAP occupies E23..E25.
  - DATA occupies E25..E48.
  - done is high for the single cycle after E48.
  - busy falls at E49.
- Total latency with defaults: 49 cycles from the start edge to done high. In general: 2·PHASE_LEN + GAP_LEN + 1.
- rdata is updated on the edge where the DATA counter equals SAMPLE_AT and is stable before done rises.
- bus_oe and bus_out change on the same edge as en_tim, so the bus is valid for the generator's whole AD-low window.
- Reset asserted mid-transaction forces all outputs to reset values immediately, without waiting for a clock edge.
  - done is not pulsed and rdata is cleared.
  - After release, the block sits in IDLE and needs a new start.
- Write transactions leave rdata unchanged.

## Test plan
- Reset: hold resetAD_n=0 with start=1 -> all outputs at reset values; no transaction starts after release until start is pulsed again.
- Write: addr=8'h0A, wdata=8'h26, rw=0 ->
  - bus_out=8'h0A with bus_oe=1 and c_ad_tim=1 for 23 cycles;
  - then 2 cycles with en_tim=0 and bus_oe=0;
  - then bus_out=8'h26 for 23 cycles with c_ad_tim=1;
  - done pulses 49 cycles after the start edge; rdata unchanged.
- Read: addr=8'h04, rw=1, bus_in=8'h59 only during DATA counts 14..16 (8'hFF elsewhere) ->
  - in DATA: c_ad_tim=0 and bus_oe=0;
  - rdata=8'h59 when done rises.
- Busy rejection: pulse start again at cycle 10 and cycle 30 of a transaction -> neither is queued; exactly one done occurs; busy stays low after it.
- Back-to-back: hold start=1 continuously -> each transaction is 49 cycles plus 1 IDLE cycle; done pulses are 50 cycles apart.
- Mid-op reset: assert resetAD_n=0 during the DATA phase of a read -> en_tim, bus_oe and busy go low asynchronously; rdata=8'h00; no done pulse.
